// File: rtl/seg7_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared types and helpers for the 7-segment scan driver:
//                conversion FSM state encoding, blank segment pattern and a
//                BCD-nibble to active-low segment decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Segment order is {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam int         DIGITS_MAX = 4;

    // Nibbles 10-15 never come out of the converter; they decode to all-off.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] r;
        case (nib)
            4'd0:    r = 7'b1000000;
            4'd1:    r = 7'b1111001;
            4'd2:    r = 7'b0100100;
            4'd3:    r = 7'b0110000;
            4'd4:    r = 7'b0011001;
            4'd5:    r = 7'b0010010;
            4'd6:    r = 7'b0000010;
            4'd7:    r = 7'b1111000;
            4'd8:    r = 7'b0000000;
            4'd9:    r = 7'b0010000;
            default: r = SEG_BLANK;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver_if
//  Description : Bundle of the scan driver's data and display signals.
//                  data_in   - binary value to show (master -> slave)
//                  blank_lz  - leading-zero blanking enable (master -> slave)
//                  an        - digit enables, active-low (slave -> master)
//                  seg       - segments {g,f,e,d,c,b,a}, active-low
//                  dp        - decimal point, active-low
//                  bcd_valid - pulse when the displayed value updates
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_driver_if #(
    parameter int DATA_W = 11,
    parameter int DIGITS = 4
);
    logic [DATA_W-1:0] data_in;
    logic              blank_lz;
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;
    logic              dp;
    logic              bcd_valid;

    modport master (
        output data_in, blank_lz,
        input  an, seg, dp, bcd_valid
    );

    modport slave (
        input  data_in, blank_lz,
        output an, seg, dp, bcd_valid
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver_bin2bcd.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble converter. Free-running loop of
//                IDLE (sample) -> SHIFT x DATA_W -> LOAD, one result every
//                DATA_W+2 cycles.
//  Ports       : clk, rst_n    - clock, async active-low reset
//                bin_in        - binary input, sampled only in IDLE
//                bcd_out       - BCD accumulator, valid while bcd_valid=1
//                bcd_valid     - high for the single LOAD cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int DATA_W = 11,
    parameter int DIGITS = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic [DATA_W-1:0]     bin_in,
    output logic      [4*DIGITS-1:0]   bcd_out,
    output logic                       bcd_valid
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [DATA_W-1:0]  r_bin;
    logic [CNT_W-1:0]   r_cnt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; r_cnt==1 means the last shift is happening now
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = SHIFT;
            SHIFT:   w_state_nxt = (r_cnt == CNT_W'(1)) ? LOAD : SHIFT;
            LOAD:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Add-3 correction applied to every nibble before each shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd <= '0;
            r_bin <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_bin <= bin_in;
                    r_bcd <= '0;
                    r_cnt <= CNT_W'(DATA_W);
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj[BCD_W-2:0], r_bin, 1'b0};
                    r_cnt          <= r_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        bcd_out   = r_bcd;
        bcd_valid = (r_state == LOAD);
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Converts a binary count to BCD and time-multiplexes the
//                digits onto a common-anode 7-segment display with optional
//                leading-zero blanking and a fixed decimal point.
//  Ports       : clk    - system clock
//                rst_n  - asynchronous active-low reset
//                bus    - seg7_scan_driver_if.slave (data_in, blank_lz in;
//                         an, seg, dp, bcd_valid out)
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DATA_W   = 11,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DP_POS   = 1
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    seg7_scan_driver_if.slave   bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [BCD_W-1:0]  w_bcd;
    logic              w_bcd_valid;

    logic [BCD_W-1:0]  r_disp;
    logic [DIV_W-1:0]  r_div;
    logic [IDX_W-1:0]  r_idx;
    logic [DIGITS-1:0] r_an;
    logic [6:0]        r_seg;
    logic              r_dp;
    logic              r_bcd_valid;

    logic              w_div_tc;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              w_upper_zero;
    logic [3:0]        w_digit;
    logic              w_digit_blank;
    logic [DIGITS-1:0] w_an_nxt;
    logic [6:0]        w_seg_nxt;
    logic              w_dp_nxt;

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk       (clk),
        .rst_n     (rst_n),
        .bin_in    (bus.data_in),
        .bcd_out   (w_bcd),
        .bcd_valid (w_bcd_valid)
    );

    assign w_div_tc  = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_idx_nxt = !w_div_tc                     ? r_idx :
                       (r_idx == IDX_W'(DIGITS - 1)) ? '0    :
                                                       r_idx + IDX_W'(1);

    // Walk digits from the top so w_upper_zero means "this digit and every
    // higher one are zero"; digit 0 is never blanked.
    always_comb begin
        w_upper_zero  = 1'b1;
        w_digit       = '0;
        w_digit_blank = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_upper_zero = w_upper_zero & (r_disp[4*k +: 4] == 4'd0);
            if (w_idx_nxt == IDX_W'(k)) begin
                w_digit       = r_disp[4*k +: 4];
                w_digit_blank = bus.blank_lz & w_upper_zero & (k != 0);
            end
        end
    end

    // Outputs are computed from the index being loaded on this edge so the
    // anode, segments and dp all switch together.
    assign w_an_nxt  = ~(DIGITS'(1) << w_idx_nxt);
    assign w_seg_nxt = w_digit_blank ? SEG_BLANK : seg_decode(w_digit);
    assign w_dp_nxt  = ((DP_POS < DIGITS) && (int'(w_idx_nxt) == DP_POS)) ? 1'b0 : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp      <= '0;
            r_div       <= '0;
            r_idx       <= '0;
            r_an        <= '1;
            r_seg       <= SEG_BLANK;
            r_dp        <= 1'b1;
            r_bcd_valid <= 1'b0;
        end else begin
            if (w_bcd_valid)
                r_disp <= w_bcd;
            r_bcd_valid <= w_bcd_valid;
            r_div       <= w_div_tc ? '0 : r_div + DIV_W'(1);
            r_idx       <= w_idx_nxt;
            r_an        <= w_an_nxt;
            r_seg       <= w_seg_nxt;
            r_dp        <= w_dp_nxt;
        end
    end

    assign bus.an        = r_an;
    assign bus.seg       = r_seg;
    assign bus.dp        = r_dp;
    assign bus.bcd_valid = r_bcd_valid;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Self-checking bench for seg7_scan_driver. Two instances
//                (SCAN_DIV=4/DP_POS=1 and SCAN_DIV=2/DP_POS=4) share clock,
//                reset and stimulus. Values sampled by the converter are
//                queued per instance; a negedge monitor pops on bcd_valid and
//                checks every displayed digit against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;
    localparam int DATA_W = 11;
    localparam int DIGITS = 4;
    localparam int PERIOD = DATA_W + 2;
    localparam int DIV_A  = 4;
    localparam int DIV_B  = 2;
    localparam int DP_A   = 1;
    localparam int DP_B   = 4;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic [DATA_W-1:0] data_in  = '0;
    logic              blank_lz = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.DATA_W(DATA_W), .DIGITS(DIGITS)) bus_a ();
    seg7_scan_driver_if #(.DATA_W(DATA_W), .DIGITS(DIGITS)) bus_b ();

    assign bus_a.data_in  = data_in;
    assign bus_a.blank_lz = blank_lz;
    assign bus_b.data_in  = data_in;
    assign bus_b.blank_lz = blank_lz;

    seg7_scan_driver #(.DATA_W(DATA_W), .DIGITS(DIGITS), .SCAN_DIV(DIV_A), .DP_POS(DP_A))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    seg7_scan_driver #(.DATA_W(DATA_W), .DIGITS(DIGITS), .SCAN_DIV(DIV_B), .DP_POS(DP_B))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    // Standard active-low {g,f,e,d,c,b,a} patterns for 0..9
    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int   e;            // rising edges since reset release
    logic blank_e;      // blank_lz as seen at the most recent edge
    int   q   [2][$];   // expected values, one queue per instance
    int   disp[2];      // value the model believes is on display

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d, t=%0t)", name, act, exp, e, $time);
        end
    endtask

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int k, input logic bl);
        if (bl && k >= 1 && v < pow10(k)) return 7'h7f;
        return seg_tbl[(v / pow10(k)) % 10];
    endfunction

    // Converter samples data_in on edges 1, 1+PERIOD, ... after reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e <= 0;
            q[0].delete();
            q[1].delete();
        end else begin
            e       <= e + 1;
            blank_e <= blank_lz;
            if ((e + 1) % PERIOD == 1) begin
                q[0].push_back(int'(data_in));
                q[1].push_back(int'(data_in));
            end
        end
    end

    task automatic check_one(input int d, input string tag, input logic [3:0] an,
                             input logic [6:0] seg, input logic dp, input logic bv,
                             input int div, input int dppos);
        int         idx;
        logic [3:0] an_exp;
        idx    = (e / div) % DIGITS;
        an_exp = ~(4'b0001 << idx);
        chk({tag, "_bcd_valid"}, int'(bv), (e % PERIOD == 0) ? 1 : 0);
        chk({tag, "_an"},  int'(an),  int'(an_exp));
        chk({tag, "_seg"}, int'(seg), int'(exp_seg(disp[d], idx, blank_e)));
        chk({tag, "_dp"},  int'(dp),  (idx == dppos) ? 0 : 1);
        if (bv) begin
            if (q[d].size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s_scoreboard: bcd_valid with no expected value queued (edge %0d)", tag, e);
            end else begin
                disp[d] = q[d].pop_front();
            end
        end
    endtask

    always @(negedge clk) begin
        if (e == 0) begin
            disp[0] = 0;
            disp[1] = 0;
        end else if (rst_n) begin
            check_one(0, "a", bus_a.an, bus_a.seg, bus_a.dp, bus_a.bcd_valid, DIV_A, DP_A);
            check_one(1, "b", bus_b.an, bus_b.seg, bus_b.dp, bus_b.bcd_valid, DIV_B, DP_B);
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_an_a"},  int'(bus_a.an),        'hf);
        chk({tag, "_seg_a"}, int'(bus_a.seg),       'h7f);
        chk({tag, "_dp_a"},  int'(bus_a.dp),        1);
        chk({tag, "_bv_a"},  int'(bus_a.bcd_valid), 0);
        chk({tag, "_an_b"},  int'(bus_b.an),        'hf);
        chk({tag, "_seg_b"}, int'(bus_b.seg),       'h7f);
    endtask

    // Bounded wait for a given phase of the conversion period
    task automatic wait_phase(input int ph);
        bit hit = 0;
        for (int i = 0; i < 2 * PERIOD && !hit; i++) begin
            @(negedge clk);
            if (e % PERIOD == ph) hit = 1;
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL wait_phase: phase %0d not reached", ph);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        data_in  = 11'd2047;
        blank_lz = 1'b0;
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        release_reset();

        // Full scale, no blanking
        repeat (60) @(negedge clk);

        // Small value with and without leading-zero blanking
        data_in  = 11'd5;
        blank_lz = 1'b1;
        repeat (40) @(negedge clk);
        blank_lz = 1'b0;
        repeat (40) @(negedge clk);

        // Value changed part-way through a conversion
        data_in = 11'd100;
        wait_phase(2);
        wait_phase(5);
        data_in = 11'd1999;
        repeat (40) @(negedge clk);

        // Reset in the middle of a conversion
        data_in  = 11'd1234;
        blank_lz = 1'b1;
        wait_phase(2);
        wait_phase(4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("midrst_hold");
        release_reset();
        repeat (40) @(negedge clk);

        // Randomized values and blanking
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0)  data_in  = DATA_W'($urandom_range(0, 2047));
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
        end

        // Zero with blanking, then zero without
        data_in  = '0;
        blank_lz = 1'b1;
        repeat (30) @(negedge clk);
        blank_lz = 1'b0;
        repeat (30) @(negedge clk);

        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
